// File: rtl/vc_test_mem_req_gen_if.sv
// Request/response channel pair between the memory test generator and the test memory.
interface vc_test_mem_req_gen_if #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32
);
  localparam int c_len_nbits  = (p_data_nbits > 8) ? $clog2(p_data_nbits / 8) : 1;
  localparam int c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits;
  localparam int c_resp_nbits = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits;

  // Both channels: a transfer happens on a clk edge where val && rdy; the sender
  // raises val without waiting for rdy and holds val and msg stable until that edge.
  logic                    memreq_val;
  logic                    memreq_rdy;
  logic [c_req_nbits-1:0]  memreq_msg;
  logic                    memresp_val;
  logic                    memresp_rdy;
  logic [c_resp_nbits-1:0] memresp_msg;

  modport master (
    output memreq_val, memreq_msg, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_msg
  );

  modport slave (
    input  memreq_val, memreq_msg, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_msg
  );
endinterface

// File: rtl/vc_test_mem_req_gen.sv
// Memory test generator: writes seed+i to base+4*i, reads every word back and checks responses.
// Define VC_TEST_MEM_REQ_GEN_STOP_ON_ERR_EN to end the run at the first detected error.
module vc_test_mem_req_gen #(
  parameter int p_opaque_nbits    = 8,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 32,
  parameter int p_max_outstanding = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             num_words,
  input  logic [p_addr_nbits-1:0] base_addr,
  input  logic [p_data_nbits-1:0] seed,
  vc_test_mem_req_gen_if.master   mem,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [p_addr_nbits-1:0] first_err_addr,
  output logic [2:0]              dbg_state
);
  localparam int c_len_nbits  = (p_data_nbits > 8) ? $clog2(p_data_nbits / 8) : 1;
  localparam int c_resp_nbits = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits;
  localparam logic [2:0] c_type_read  = 3'd0;
  localparam logic [2:0] c_type_write = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WR_DRAIN, S_READ, S_RD_DRAIN, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             nwords_q, issue_cnt_q, resp_cnt_q;
  logic [p_addr_nbits-1:0] base_q;
  logic [p_data_nbits-1:0] seed_q;
  logic [3:0]              outst_q;

  logic issue_phase, write_phase, resp_phase;
  logic req_val, req_fire, resp_fire, resp_spurious, resp_bad;
  logic launch, clr_cnt;

  logic [2:0]                rsp_type;
  logic [p_opaque_nbits-1:0] rsp_opaque;
  logic [p_data_nbits-1:0]   rsp_data;
  logic [c_len_nbits-1:0]    unused_rsp_len;
  logic [2:0]                req_type;
  logic [p_addr_nbits-1:0]   req_addr, err_addr;
  logic [p_data_nbits-1:0]   req_data;

  assign rsp_type       = mem.memresp_msg[c_resp_nbits-1 -: 3];
  assign rsp_opaque     = mem.memresp_msg[c_resp_nbits-4 -: p_opaque_nbits];
  assign unused_rsp_len = mem.memresp_msg[p_data_nbits +: c_len_nbits];
  assign rsp_data       = mem.memresp_msg[p_data_nbits-1:0];

  assign issue_phase = (state_q == S_WRITE) || (state_q == S_READ);
  assign write_phase = (state_q == S_WRITE) || (state_q == S_WR_DRAIN);
  assign resp_phase  = issue_phase || (state_q == S_WR_DRAIN) || (state_q == S_RD_DRAIN);

  // Issue is gated only by state and the credit count, so a stalled request
  // keeps both val and msg steady until the memory accepts it.
  assign req_val  = issue_phase && (outst_q < 4'(p_max_outstanding));
  assign req_fire = req_val && mem.memreq_rdy;
  assign req_type = write_phase ? c_type_write : c_type_read;
  assign req_addr = base_q + p_addr_nbits'({issue_cnt_q, 2'b00});
  assign req_data = (state_q == S_WRITE) ? (seed_q + p_data_nbits'(issue_cnt_q)) : '0;
  assign err_addr = base_q + p_addr_nbits'({resp_cnt_q, 2'b00});

  assign resp_fire     = resp_phase && mem.memresp_val;
  assign resp_spurious = resp_fire && (outst_q == 4'd0);
  assign resp_bad      = resp_spurious ||
                         (resp_fire &&
                          ((rsp_type != (write_phase ? c_type_write : c_type_read)) ||
                           (rsp_opaque != p_opaque_nbits'(resp_cnt_q)) ||
                           (!write_phase && (rsp_data != seed_q + p_data_nbits'(resp_cnt_q)))));

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    clr_cnt = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = (num_words == 16'd0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE:    if (req_fire && (issue_cnt_q + 16'd1 == nwords_q)) state_d = S_WR_DRAIN;
      S_WR_DRAIN: if (outst_q == 4'd0) begin
                    clr_cnt = 1'b1;
                    state_d = S_READ;
                  end
      S_READ:     if (req_fire && (issue_cnt_q + 16'd1 == nwords_q)) state_d = S_RD_DRAIN;
      S_RD_DRAIN: if (outst_q == 4'd0) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
`ifdef VC_TEST_MEM_REQ_GEN_STOP_ON_ERR_EN
    if (resp_bad) begin
      clr_cnt = 1'b0;
      state_d = S_DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      nwords_q       <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      issue_cnt_q    <= '0;
      resp_cnt_q     <= '0;
      outst_q        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        nwords_q       <= num_words;
        base_q         <= base_addr;
        seed_q         <= seed;
        issue_cnt_q    <= '0;
        resp_cnt_q     <= '0;
        outst_q        <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        if (clr_cnt) begin
          issue_cnt_q <= '0;
          resp_cnt_q  <= '0;
          outst_q     <= '0;
        end else begin
          if (req_fire) issue_cnt_q <= issue_cnt_q + 16'd1;
          if (resp_fire && !resp_spurious) resp_cnt_q <= resp_cnt_q + 16'd1;
          case ({req_fire, resp_fire && !resp_spurious})
            2'b10:   outst_q <= outst_q + 4'd1;
            2'b01:   outst_q <= outst_q - 4'd1;
            default: outst_q <= outst_q;
          endcase
        end
        // err_count saturates, so it only reads zero before the first error.
        if (resp_bad) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'd0) first_err_addr <= err_addr;
        end
      end
    end
  end

  assign mem.memreq_val  = req_val;
  assign mem.memreq_msg  = {req_type, p_opaque_nbits'(issue_cnt_q), req_addr,
                            {c_len_nbits{1'b0}}, req_data};
  assign mem.memresp_rdy = resp_phase;
  assign busy            = resp_phase;
  assign done            = (state_q == S_DONE);
  assign pass            = (state_q == S_DONE) && (err_count == 16'd0);
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_vc_test_mem_req_gen.sv
// Bench for vc_test_mem_req_gen: vector table of whole runs against a memory model,
// request scoreboard, and hand sequences for backpressure and mid-run reset.
`timescale 1ns/1ps
module tb_vc_test_mem_req_gen;
  localparam int O = 8, A = 32, D = 32, MAXO = 4;
  localparam int REQ_W = 3 + O + A + 2 + D;
  localparam int RSP_W = 3 + O + 2 + D;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [15:0]   num_words;
  logic [A-1:0]  base_addr;
  logic [D-1:0]  seed;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [A-1:0]  first_err_addr;
  logic [2:0]    dbg_state;

  vc_test_mem_req_gen_if #(.p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D)) mem_if ();

  vc_test_mem_req_gen #(
    .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D), .p_max_outstanding(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .base_addr(base_addr), .seed(seed), .mem(mem_if.master),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model knobs (written by the test sequence only)
  int          rdy_mode     = 0;
  bit          rsp_rand     = 1'b0;
  bit          hold_all     = 1'b0;
  bit          hold_reads   = 1'b0;
  bit          corrupt_en   = 1'b0;
  logic [A-1:0] corrupt_addr = '0;
  bit          flush_req    = 1'b0;

  // memory model state (written by the model processes only)
  logic [RSP_W-1:0] pend_q[$];
  bit               pend_bad_q[$];
  logic [REQ_W-1:0] got_q[$];
  logic [D-1:0]     mem_a[logic [A-1:0]];
  int cyc = 0, acc_cnt = 0, rd_acc = 0, val_cycles = 0;
  int inflight = 0, max_inflight = 0, corrupt_cyc = -1;

  // scoreboard
  logic [REQ_W-1:0] exp_q[$];
  int rd_ptr = 0;
  int total = 0, bad = 0;
  int done_cyc = -1;

  typedef struct {
    logic [15:0]  n;
    logic [A-1:0] base;
    logic [D-1:0] seed;
    int           rdy_mode;
    bit           rsp_rand;
    bit           corrupt_en;
    logic [A-1:0] corrupt_addr;
    logic [15:0]  exp_err;
    logic [A-1:0] exp_first;
    bit           exp_pass;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clk) begin
    logic [REQ_W-1:0] m;
    logic [2:0]       t;
    logic [O-1:0]     o;
    logic [A-1:0]     a;
    logic [D-1:0]     d;
    bit               corrupted;
    cyc++;
    if (flush_req) begin
      pend_q.delete();
      pend_bad_q.delete();
      inflight     = 0;
      max_inflight = 0;
    end else begin
      if (mem_if.memreq_val === 1'b1) val_cycles++;
      if (mem_if.memresp_val && mem_if.memresp_rdy && pend_q.size() > 0) begin
        if (pend_bad_q[0]) corrupt_cyc = cyc;
        void'(pend_q.pop_front());
        void'(pend_bad_q.pop_front());
        inflight--;
      end
      if (mem_if.memreq_val === 1'b1 && mem_if.memreq_rdy) begin
        m = mem_if.memreq_msg;
        got_q.push_back(m);
        acc_cnt++;
        t = m[REQ_W-1 -: 3];
        o = m[REQ_W-4 -: O];
        a = m[D+2 +: A];
        d = m[D-1:0];
        if (t == 3'd1) begin
          mem_a[a] = d;
          pend_q.push_back({3'd1, o, 2'b00, {D{1'b0}}});
          pend_bad_q.push_back(1'b0);
        end else begin
          rd_acc++;
          d = mem_a.exists(a) ? mem_a[a] : '0;
          corrupted = corrupt_en && (a == corrupt_addr);
          if (corrupted) d = d ^ 32'h0000_0100;
          pend_q.push_back({3'd0, o, 2'b00, d});
          pend_bad_q.push_back(corrupted);
        end
        inflight++;
      end
      if (inflight > max_inflight) max_inflight = inflight;
    end
  end

  always begin
    @(negedge clk);
    #1;
    case (rdy_mode)
      0:       mem_if.memreq_rdy = 1'b0;
      1:       mem_if.memreq_rdy = 1'b1;
      default: mem_if.memreq_rdy = 1'($urandom_range(0, 1));
    endcase
    if (pend_q.size() > 0 && !hold_all &&
        !(hold_reads && pend_q[0][RSP_W-1 -: 3] == 3'd0) &&
        (!rsp_rand || mem_if.memresp_val || $urandom_range(0, 2) != 0)) begin
      mem_if.memresp_val = 1'b1;
      mem_if.memresp_msg = pend_q[0];
    end else begin
      mem_if.memresp_val = 1'b0;
      mem_if.memresp_msg = '0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [O-1:0] o,
                                              input logic [A-1:0] a, input logic [D-1:0] d);
    return {t, o, a, 2'b00, d};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic flush_model();
    flush_req = 1'b1;
    repeat (2) @(negedge clk);
    flush_req = 1'b0;
    rd_ptr = got_q.size();
    exp_q.delete();
  endtask

  task automatic push_expected(input int n, input logic [A-1:0] b, input logic [D-1:0] s);
    for (int i = 0; i < n; i++) exp_q.push_back(mk_req(3'd1, O'(i), b + A'(4 * i), s + D'(i)));
    for (int i = 0; i < n; i++) exp_q.push_back(mk_req(3'd0, O'(i), b + A'(4 * i), '0));
  endtask

  task automatic start_run(input logic [15:0] n, input logic [A-1:0] b, input logic [D-1:0] s);
    @(negedge clk);
    num_words = n;
    base_addr = b;
    seed      = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    done_cyc = cyc;
    check("done_within_budget", done, 1'b1);
  endtask

  task automatic drain_sb(input bit allow_left);
    while (rd_ptr < got_q.size()) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra_req: got=%0h want=none", got_q[rd_ptr]);
      end else begin
        check("sb_req", got_q[rd_ptr], exp_q.pop_front());
      end
      rd_ptr++;
    end
    if (!allow_left) check("sb_left", exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    flush_model();
    rdy_mode     = v.rdy_mode;
    rsp_rand     = v.rsp_rand;
    corrupt_en   = v.corrupt_en;
    corrupt_addr = v.corrupt_addr;
    hold_all     = 1'b0;
    hold_reads   = 1'b0;
    push_expected(int'(v.n), v.base, v.seed);
    start_run(v.n, v.base, v.seed);
    wait_done(4000);
    check("run_pass", pass, v.exp_pass);
    check("run_err_count", err_count, v.exp_err);
    check("run_first_err_addr", first_err_addr, v.exp_first);
    check("run_busy_low", busy, 1'b0);
    check("run_max_outstanding", (max_inflight <= MAXO), 1'b1);
`ifdef VC_TEST_MEM_REQ_GEN_STOP_ON_ERR_EN
    if (v.corrupt_en) check("stop_next_cycle", done_cyc, corrupt_cyc);
    drain_sb(v.exp_err != 0);
`else
    drain_sb(1'b0);
`endif
  endtask

  initial begin
    int k, acc_base, rd_base, val_base;
    logic [REQ_W-1:0] held;
    vec_t v;

    vecs[0] = '{16'd8,  32'h0000_0100, 32'h0000_A000, 1, 1'b0, 1'b0, 32'h0,       16'd0, 32'h0,       1'b1};
    vecs[1] = '{16'd8,  32'h0000_0200, 32'h0000_1234, 1, 1'b0, 1'b1, 32'h20C,     16'd1, 32'h20C,     1'b0};
    vecs[2] = '{16'd4,  32'hFFFF_FFF8, 32'hFFFF_FFFE, 2, 1'b1, 1'b0, 32'h0,       16'd0, 32'h0,       1'b1};
    vecs[3] = '{16'd13, 32'h0000_0040, 32'h0000_0055, 2, 1'b1, 1'b0, 32'h0,       16'd0, 32'h0,       1'b1};
    vecs[4] = '{16'd1,  32'h0000_0000, 32'h0000_0000, 1, 1'b1, 1'b0, 32'h0,       16'd0, 32'h0,       1'b1};
    vecs[5] = '{16'd5,  32'h0000_0300, 32'h0000_0007, 2, 1'b1, 1'b1, 32'h300,     16'd1, 32'h300,     1'b0};

    reset = 1'b0;
    start = 1'b0;
    num_words = '0;
    base_addr = '0;
    seed = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    check("rst_first_err_addr", first_err_addr, 32'd0);
    check("rst_memreq_val", mem_if.memreq_val, 1'b0);
    check("rst_memresp_rdy", mem_if.memresp_rdy, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // zero-length run finishes one cycle after start without any request
    val_base = val_cycles;
    start_run(16'd0, 32'h100, 32'h1);
    check("zero_done", done, 1'b1);
    check("zero_pass", pass, 1'b1);
    repeat (3) @(negedge clk);
    check("zero_no_req", val_cycles - val_base, 0);
    check("zero_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // backpressure: credit limit, then a stalled request must hold val and msg
    flush_model();
    rdy_mode = 1; rsp_rand = 1'b0; corrupt_en = 1'b0; hold_reads = 1'b0; hold_all = 1'b1;
    push_expected(8, 32'h400, 32'h9000);
    acc_base = acc_cnt;
    start_run(16'd8, 32'h400, 32'h9000);
    repeat (10) @(negedge clk);
    check("bp_issued_at_limit", acc_cnt - acc_base, MAXO);
    check("bp_val_blocked", mem_if.memreq_val, 1'b0);
    check("bp_max_outstanding", max_inflight, MAXO);
    rdy_mode = 0;
    hold_all = 1'b0;
    k = 0;
    while (!mem_if.memreq_val && k < 50) begin
      @(negedge clk);
      k++;
    end
    hold_all = 1'b1;
    check("bp_val_up", mem_if.memreq_val, 1'b1);
    held = mem_if.memreq_msg;
    check("bp_msg_word4", held, mk_req(3'd1, 8'd4, 32'h410, 32'h9004));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_val_hold", mem_if.memreq_val, 1'b1);
      check("bp_msg_hold", mem_if.memreq_msg, held);
    end
    check("bp_outstanding_cap", (max_inflight <= MAXO), 1'b1);
    rdy_mode = 2; rsp_rand = 1'b1; hold_all = 1'b0;
    wait_done(4000);
    check("bp_pass", pass, 1'b1);
    check("bp_err_count", err_count, 16'd0);
    drain_sb(1'b0);

    // reset in the read phase with two reads in flight
    flush_model();
    rdy_mode = 1; rsp_rand = 1'b0; hold_all = 1'b0; hold_reads = 1'b1;
    push_expected(8, 32'h500, 32'h33);
    rd_base = rd_acc;
    start_run(16'd8, 32'h500, 32'h33);
    k = 0;
    while ((rd_acc - rd_base) < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    rdy_mode = 0;
    @(negedge clk);
    check("mid_two_reads", rd_acc - rd_base, 2);
    check("mid_busy_before", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_memreq_val", mem_if.memreq_val, 1'b0);
    check("mid_rst_memresp_rdy", mem_if.memresp_rdy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err_count, 16'd0);
    hold_reads = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_idle_ignores_resp", err_count, 16'd0);
    check("mid_idle_busy", busy, 1'b0);
    v = '{16'd6, 32'h0000_0600, 32'h0000_4444, 2, 1'b1, 1'b0, 32'h0, 16'd0, 32'h0, 1'b1};
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
